// File: rtl/vote_tally_collector_if.sv
// rtl/vote_tally_collector_if.sv - session control, ballot and judge-vote handshakes
// Signals:
//   start, close               session control pulses
//   ballot_valid/id/ready      ballot handshake (ready driven by the collector)
//   judge_valid/vote/ready     judge-vote handshake (ready driven by the collector)
// Modports: master = vote source, slave = vote_tally_collector.
interface vote_tally_collector_if;
    logic       start;
    logic       close;
    logic       ballot_valid;
    logic [1:0] ballot_id;
    logic       ballot_ready;
    logic       judge_valid;
    logic [1:0] judge_vote;
    logic       judge_ready;

    modport master (
        output start, close, ballot_valid, ballot_id, judge_valid, judge_vote,
        input  ballot_ready, judge_ready
    );

    modport slave (
        input  start, close, ballot_valid, ballot_id, judge_valid, judge_vote,
        output ballot_ready, judge_ready
    );
endinterface

// File: rtl/vote_tally_collector.sv
// rtl/vote_tally_collector.sv - serial ballot tally and judge-vote capture ahead of the result stage
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   vif (slave)                start/close, ballot and judge-vote handshakes
//   VA..VD                     per-candidate counts (IDs 00..11), saturating
//   J1..J4                     judge votes in arrival order
//   tally_done                 session complete; counts/judges frozen while high
//   busy                       session in VOTING or JUDGING
//   overflow                   sticky: a ballot hit a saturated counter
// Optional: define VOTE_LIMIT_EN to end VOTING automatically after MAX_BALLOTS
// accepted ballots.
module vote_tally_collector #(
    parameter int CNT_W       = 6,
    parameter int MAX_BALLOTS = 63
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vote_tally_collector_if.slave vif,
    output logic [CNT_W-1:0]     VA,
    output logic [CNT_W-1:0]     VB,
    output logic [CNT_W-1:0]     VC,
    output logic [CNT_W-1:0]     VD,
    output logic [1:0]           J1,
    output logic [1:0]           J2,
    output logic [1:0]           J3,
    output logic [1:0]           J4,
    output logic                 tally_done,
    output logic                 busy,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VOTING,
        S_JUDGING,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt [4];
    logic [1:0]       jreg [4];
    logic [1:0]       judge_idx;
    logic             ballot_ready;
    logic             judge_ready;
    logic             session_open;
    logic             limit_hit;
    logic             ballot_acc;
    logic             judge_acc;

`ifdef VOTE_LIMIT_EN
    localparam int TOT_W = $clog2(MAX_BALLOTS + 1);

    // Counts every accepted ballot, including ones dropped on a saturated
    // candidate counter, so the session limit is on ballots offered.
    logic [TOT_W-1:0] total;

    assign limit_hit = (total == TOT_W'(MAX_BALLOTS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
        end else if (session_open) begin
            total <= '0;
        end else if (ballot_acc) begin
            total <= total + 1'b1;
        end
    end
`else
    logic unused_limit;

    assign limit_hit    = 1'b0;
    assign unused_limit = (MAX_BALLOTS > 0);
`endif

    assign ballot_acc       = vif.ballot_valid & ballot_ready;
    assign judge_acc        = vif.judge_valid & judge_ready;
    assign vif.ballot_ready = ballot_ready;
    assign vif.judge_ready  = judge_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        ballot_ready = 1'b0;
        judge_ready  = 1'b0;
        session_open = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (vif.start) begin
                    next_state   = S_VOTING;
                    session_open = 1'b1;
                end
            end
            S_VOTING: begin
                // Once the limit is reached no further ballot is taken and
                // the session moves on exactly as if close had arrived.
                ballot_ready = ~limit_hit;
                if (vif.close || limit_hit) begin
                    next_state = S_JUDGING;
                end
            end
            S_JUDGING: begin
                judge_ready = 1'b1;
                if (vif.judge_valid && judge_idx == 2'd3) begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            overflow <= 1'b0;
        end else if (session_open) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            overflow <= 1'b0;
        end else if (ballot_acc) begin
            if (cnt[vif.ballot_id] == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                cnt[vif.ballot_id] <= cnt[vif.ballot_id] + 1'b1;
            end
        end
    end

    // The 2-bit index wraps back to 0 after the fourth vote, ready for the
    // next session without an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                jreg[i] <= 2'b00;
            end
            judge_idx <= 2'd0;
        end else if (session_open) begin
            for (int i = 0; i < 4; i++) begin
                jreg[i] <= 2'b00;
            end
            judge_idx <= 2'd0;
        end else if (judge_acc) begin
            jreg[judge_idx] <= vif.judge_vote;
            judge_idx       <= judge_idx + 2'd1;
        end
    end

    // Status flags follow the state the FSM is about to enter, so they are
    // registered yet line up with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tally_done <= (next_state == S_DONE);
            busy       <= (next_state == S_VOTING) || (next_state == S_JUDGING);
        end
    end

    assign VA = cnt[0];
    assign VB = cnt[1];
    assign VC = cnt[2];
    assign VD = cnt[3];
    assign J1 = jreg[0];
    assign J2 = jreg[1];
    assign J3 = jreg[2];
    assign J4 = jreg[3];

endmodule

// File: tb/tb_vote_tally_collector.sv
// tb/tb_vote_tally_collector.sv - randomized and directed bench for vote_tally_collector
module tb_vote_tally_collector;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int MB    = 5;

    localparam int P_IDLE  = 0;
    localparam int P_VOTE  = 1;
    localparam int P_JUDGE = 2;
    localparam int P_DONE  = 3;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] va, vb, vc, vd;
    logic [1:0]       j1, j2, j3, j4;
    logic             tally_done, busy, overflow;

    vote_tally_collector_if vif ();

    vote_tally_collector #(
        .CNT_W       (CNT_W),
        .MAX_BALLOTS (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vif        (vif),
        .VA         (va),
        .VB         (vb),
        .VC         (vc),
        .VD         (vd),
        .J1         (j1),
        .J2         (j2),
        .J3         (j3),
        .J4         (j4),
        .tally_done (tally_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_bad    = 0;

    // Reference model: session phase, per-candidate tallies, judge list.
    int         phase;
    int         mcnt [4];
    logic [1:0] mj [$];
    int         mtot;
    bit         movf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit limit_reached();
`ifdef VOTE_LIMIT_EN
        return (mtot >= MB);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_bready();
        return (phase == P_VOTE) && !limit_reached();
    endfunction

    function automatic int exp_j(input int k);
        return (k < mj.size()) ? int'(mj[k]) : 0;
    endfunction

    task automatic model_reset();
        phase = P_IDLE;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        mj.delete();
        mtot = 0;
        movf = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit c, input bit bv, input logic [1:0] bid,
                              input bit jv, input logic [1:0] jvt);
        bit br;
        bit lim;
        br  = exp_bready();
        lim = limit_reached();
        case (phase)
            P_IDLE, P_DONE: begin
                if (s) begin
                    for (int i = 0; i < 4; i++) mcnt[i] = 0;
                    mj.delete();
                    mtot  = 0;
                    movf  = 1'b0;
                    phase = P_VOTE;
                end
            end
            P_VOTE: begin
                if (bv && br) begin
                    mtot++;
                    if (mcnt[bid] == CMAX) movf = 1'b1;
                    else mcnt[bid]++;
                end
                if (c || lim) phase = P_JUDGE;
            end
            default: begin
                if (jv) begin
                    mj.push_back(jvt);
                    if (mj.size() == 4) phase = P_DONE;
                end
            end
        endcase
    endtask

    task automatic check_ready();
        check("ballot_ready", vif.ballot_ready, exp_bready());
        check("judge_ready", vif.judge_ready, phase == P_JUDGE);
    endtask

    task automatic check_outputs();
        check("VA", va, mcnt[0]);
        check("VB", vb, mcnt[1]);
        check("VC", vc, mcnt[2]);
        check("VD", vd, mcnt[3]);
        check("J1", j1, exp_j(0));
        check("J2", j2, exp_j(1));
        check("J3", j3, exp_j(2));
        check("J4", j4, exp_j(3));
        check("tally_done", tally_done, phase == P_DONE);
        check("busy", busy, (phase == P_VOTE) || (phase == P_JUDGE));
        check("overflow", overflow, movf);
    endtask

    task automatic step(input bit s, input bit c, input bit bv, input logic [1:0] bid,
                        input bit jv, input logic [1:0] jvt);
        @(negedge clk);
        vif.start        = s;
        vif.close        = c;
        vif.ballot_valid = bv;
        vif.ballot_id    = bid;
        vif.judge_valid  = jv;
        vif.judge_vote   = jvt;
        #1;
        check_ready();
        @(posedge clk);
        model_edge(s, c, bv, bid, jv, jvt);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic ballot(input logic [1:0] id);
        step(1'b0, 1'b0, 1'b1, id, 1'b0, 2'd0);
    endtask

    task automatic judge(input logic [1:0] v);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, v);
    endtask

    task automatic start_session();
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic close_session();
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    initial begin
        int         ids [$];
        int         tmp;
        int         k;
        int         vb_before;
        logic [1:0] jv_set [4];

        rst_n            = 1'b0;
        vif.start        = 1'b0;
        vif.close        = 1'b0;
        vif.ballot_valid = 1'b0;
        vif.ballot_id    = 2'd0;
        vif.judge_valid  = 1'b0;
        vif.judge_vote   = 2'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_ready();
        check_outputs();
        rst_n = 1'b1;

        // Tally with interleaved ballots, then close.
        start_session();
        for (int i = 0; i < 17; i++) ids.push_back(0);
        for (int i = 0; i < 15; i++) ids.push_back(1);
        for (int i = 0; i < 15; i++) ids.push_back(2);
        for (int i = 0; i < 53; i++) ids.push_back(3);
        for (int i = ids.size() - 1; i > 0; i--) begin
            k      = $urandom_range(i, 0);
            tmp    = ids[i];
            ids[i] = ids[k];
            ids[k] = tmp;
        end
        foreach (ids[i]) ballot(2'(ids[i]));
        close_session();
`ifndef VOTE_LIMIT_EN
        check("t1_VA", va, 17);
        check("t1_VB", vb, 15);
        check("t1_VC", vc, 15);
        check("t1_VD", vd, 53);
        check("t1_ballot_ready", vif.ballot_ready, 0);
        check("t1_judge_ready", vif.judge_ready, 1);
`endif

        // Judge votes and completion latency.
        judge(2'b10);
        judge(2'b10);
        judge(2'b10);
        check("t2_not_done_early", tally_done, 0);
        judge(2'b00);
        check("t2_J1", j1, 2);
        check("t2_J2", j2, 2);
        check("t2_J3", j3, 2);
        check("t2_J4", j4, 0);
        check("t2_tally_done", tally_done, 1);
        check("t2_busy", busy, 0);

        // Saturation and sticky overflow, cleared by the next start.
        start_session();
        check("t3_done_drops", tally_done, 0);
        for (int i = 0; i < 70; i++) ballot(2'd0);
`ifndef VOTE_LIMIT_EN
        check("t3_VA_sat", va, CMAX);
        check("t3_overflow", overflow, 1);
`endif
        close_session();
        for (int i = 0; i < 4; i++) judge(2'($urandom_range(3, 0)));
        start_session();
        check("t3_ovf_clear", overflow, 0);
        check("t3_VA_clear", va, 0);

        // Ballot in the close cycle counts; the next one does not.
        ballot(2'd2);
        ballot(2'd1);
        vb_before = int'(vb);
        step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        check("t4_close_ballot", vb, vb_before + 1);
        ballot(2'd1);
        check("t4_after_close", vb, vb_before + 1);
        check("t4_judging", vif.judge_ready, 1);

        // Asynchronous reset mid-judging, then a fresh session.
        judge(2'b11);
        judge(2'b01);
        @(negedge clk);
        vif.judge_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_ready();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        start_session();
        close_session();
        jv_set[0] = 2'b01;
        jv_set[1] = 2'b11;
        jv_set[2] = 2'b00;
        jv_set[3] = 2'b10;
        for (int i = 0; i < 4; i++) judge(jv_set[i]);
        check("t5_J1", j1, 1);
        check("t5_J2", j2, 3);
        check("t5_J3", j3, 0);
        check("t5_J4", j4, 2);

        // Ballot limit (or its absence).
        start_session();
        for (int i = 0; i < 5; i++) ballot(2'(i % 4));
        idle();
        ballot(2'd3);
`ifdef VOTE_LIMIT_EN
        check("t6_auto_judging", vif.judge_ready, 1);
`else
        check("t6_still_voting", vif.ballot_ready, 1);
`endif
        check("t6_VD", vd, mcnt[3]);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(19, 0) == 0), ($urandom_range(39, 0) == 0),
                 ($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)),
                 ($urandom_range(1, 0) == 1), 2'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/vote_tally_collector.md
Name: vote_tally_collector

Overview:
Upstream stage of the election-result block. It tallies serial ballots into per-candidate counts VA..VD (candidate IDs 00,01,10,11) and then captures the four judge votes J1..J4 in order. When both are complete it raises tally_done, which drives the downstream paraoif input. Counts and judge votes are held stable in DONE so the result stage can consume them combinationally.

Parameters:
CNT_W, 6, width of each candidate counter (VA..VD).
MAX_BALLOTS, 63, session ballot limit; used only when VOTE_LIMIT_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; opens a new session.
close  input  1  single-cycle pulse; ends ballot collection.
ballot_valid  input  1  ballot present this cycle.
ballot_id  input  2  candidate voted for (00=A, 01=B, 10=C, 11=D).
ballot_ready  output  1  block accepts a ballot this cycle.
judge_valid  input  1  judge vote present this cycle.
judge_vote  input  2  judge's candidate ID.
judge_ready  output  1  block accepts a judge vote this cycle.
VA, VB, VC, VD  output  CNT_W  candidate counts.
J1, J2, J3, J4  output  2  judge votes, in arrival order.
tally_done  output  1  session complete; drives downstream paraoif.
busy  output  1  high in VOTING or JUDGING.
overflow  output  1  sticky; a ballot was dropped on a saturated counter.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; VA..VD=0; J1..J4=00; tally_done=0; busy=0; overflow=0; ballot_ready=0; judge_ready=0; judge index=0.
- States: IDLE, VOTING, JUDGING, DONE. All outputs are registered except ballot_ready and judge_ready, which decode the state combinationally.
- IDLE: start -> VOTING. Counters, judge regs, judge index and overflow clear on the same edge.
- DONE: tally_done=1 and outputs frozen. start -> VOTING with the same clearing. tally_done drops on the cycle after start.
- VOTING: ballot_ready=1 and busy=1. On ballot_valid and ballot_ready, the counter selected by ballot_id increments at that clock edge, so it is visible one cycle later.
- Saturation: a counter at 2^CNT_W-1 does not wrap. The ballot is dropped and overflow is set; it stays set until the next start.
- close in VOTING -> JUDGING. A ballot accepted in the same cycle as close is still counted.
- JUDGING: judge_ready=1 and ballot_ready=0. Each judge_valid stores judge_vote into J1, J2, J3, J4 in sequence using a 2-bit index. The fourth accepted vote moves the state to DONE, and tally_done=1 on the following cycle.
- Ignored inputs: start in VOTING or JUDGING; close outside VOTING; ballot_valid outside VOTING; judge_valid outside JUDGING.
- A mid-session reset aborts the session: all state returns to reset values immediately.
- Latency: tally_done asserts 1 cycle after the 4th judge vote is accepted. Counts are valid whenever tally_done=1.

Optional Feature:
VOTE_LIMIT_EN:
- Defined: a total-ballot counter (width clog2(MAX_BALLOTS+1)) counts accepted ballots, including ballots dropped by saturation.
- When the total reaches MAX_BALLOTS, ballot_ready drops in that cycle and the state moves to JUDGING on the next edge without needing close. close in that same cycle behaves identically.
- Not defined: no total counter exists; only close ends VOTING.

Test Plan:
1. Reset, start, then stream 17 ballots for A, 15 for B, 15 for C and 53 for D (interleaved), close -> VA=17, VB=15, VC=15, VD=53; ballot_ready=0 and judge_ready=1 after close.
2. Continue from 1 with judge votes 10,10,10,00 -> J1=10, J2=10, J3=10, J4=00; tally_done=1 exactly 1 cycle after the 4th vote; busy=0.
3. Send 70 ballots for A with CNT_W=6 -> VA saturates at 63; overflow=1; start clears overflow to 0 and VA to 0.
4. Assert close and a ballot for B in the same cycle -> VB increments by 1 and state moves to JUDGING; a ballot_valid on the next cycle is not counted.
5. Pull rst_n low during JUDGING after 2 judge votes -> all outputs return to 0 asynchronously; start, then 4 judge votes after close fill J1 to J4 fresh from J1.
6. With VOTE_LIMIT_EN and MAX_BALLOTS=5, send 5 ballots and no close -> JUDGING is entered automatically and a 6th ballot is ignored. Without the macro, the state remains VOTING after the 5 ballots.
